// File: rtl/rgbw_wrd2sout.sv
// rtl/rgbw_wrd2sout.sv - WS2812b/SK6812 RGBW word to single-wire NRZ serial transmitter
// Optional feature macro: RGBW_WRD2SOUT_AUTOLATCH_EN (underrun after bit 0 enters LATCH instead of IDLE)
module rgbw_wrd2sout #(
    parameter int NBITS     = 32,
    parameter int T0H_CLKS  = 38,
    parameter int T1H_CLKS  = 77,
    parameter int TBIT_CLKS = 120,
    parameter int TRST_CLKS = 7680
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] in_word,
    input  logic             in_latch,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sdata,
    output logic             out_busy
);

    localparam int BW = $clog2(NBITS);
    localparam logic [12:0] TBIT_LAST = 13'(TBIT_CLKS - 1);
    localparam logic [12:0] TBIT_PRE  = 13'(TBIT_CLKS - 2);
    localparam logic [12:0] TRST_LAST = 13'(TRST_CLKS - 1);
    localparam logic [BW-1:0] BIDX_TOP = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t           state;
    logic [12:0]      cnt;
    logic [NBITS-1:0] shreg;
    logic [BW-1:0]    bidx;
    logic             latch_pend;
    logic             accept;
    logic [12:0]      thi;

    assign accept = in_valid && in_ready;
    // High time of the bit currently on the line is chosen by the MSB of the shifter.
    assign thi    = shreg[NBITS-1] ? 13'(T1H_CLKS) : 13'(T0H_CLKS);

    // Bit-timing FSM; all outputs are registered so the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bidx       <= '0;
            latch_pend <= 1'b0;
            in_ready   <= 1'b0;
            out_sdata  <= 1'b0;
            out_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= in_word;
                        latch_pend <= in_latch;
                        bidx       <= BIDX_TOP;
                        cnt        <= '0;
                        state      <= HIGH;
                        out_sdata  <= 1'b1;
                        out_busy   <= 1'b1;
                        in_ready   <= 1'b0;
                    end else begin
                        in_ready   <= 1'b1;
                    end
                end
                HIGH: begin
                    cnt <= cnt + 13'd1;
                    if (cnt == thi - 13'd1) begin
                        state     <= LOW;
                        out_sdata <= 1'b0;
                    end
                end
                LOW: begin
                    if (cnt == TBIT_LAST) begin
                        in_ready <= 1'b0;
                        if (bidx != '0) begin
                            shreg     <= shreg << 1;
                            bidx      <= bidx - 1'b1;
                            cnt       <= '0;
                            state     <= HIGH;
                            out_sdata <= 1'b1;
                        end else if (latch_pend) begin
                            cnt   <= '0;
                            state <= LATCH;
                        end else if (accept) begin
                            // Seamless reload: the next word's first bit starts right on the boundary.
                            shreg      <= in_word;
                            latch_pend <= in_latch;
                            bidx       <= BIDX_TOP;
                            cnt        <= '0;
                            state      <= HIGH;
                            out_sdata  <= 1'b1;
                        end else begin
`ifdef RGBW_WRD2SOUT_AUTOLATCH_EN
                            cnt   <= '0;
                            state <= LATCH;
`else
                            cnt      <= '0;
                            state    <= IDLE;
                            out_busy <= 1'b0;
                            in_ready <= 1'b1;
`endif
                        end
                    end else begin
                        cnt      <= cnt + 13'd1;
                        // Open the accept window on the final LOW clock of bit 0 only.
                        in_ready <= (cnt == TBIT_PRE) && (bidx == '0) && !latch_pend;
                    end
                end
                LATCH: begin
                    if (cnt == TRST_LAST) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        out_busy <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_sdata <= 1'b0;
                    out_busy  <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_wrd2sout.sv
// tb/tb_rgbw_wrd2sout.sv - directed self-checking bench for rgbw_wrd2sout
module tb_rgbw_wrd2sout;

    logic        clk;
    logic        rst;
    logic [31:0] in_word;
    logic        in_latch;
    logic        in_valid;
    logic        in_ready;
    logic        out_sdata;
    logic        out_busy;

    int total;
    int bad;
    int wt;
    int wt2;

`ifdef RGBW_WRD2SOUT_AUTOLATCH_EN
    localparam int AL = 7680;
`else
    localparam int AL = 0;
`endif

    rgbw_wrd2sout dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_latch  (in_latch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sdata (out_sdata),
        .out_busy  (out_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a word at a negedge, wait for in_ready, return on the negedge after the accept.
    task automatic send(input logic [31:0] w, input logic l, output int waited);
        in_word  = w;
        in_latch = l;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 10000) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout word=%h waited=%0d", w, waited);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_latch = 1'b0;
    endtask

    // Measure n bits starting at the first high cycle; bits[n-1] is sent first.
    task automatic measure(input string name, input logic [63:0] bits, input int n,
                           input int tail, input bit chk_ready);
        int h;
        int l;
        int t;
        int errs;
        int thi;
        bit busy_lost;
        busy_lost = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            thi = bits[i] ? 77 : 38;
            h = 0;
            while (out_sdata === 1'b1 && h < 200) begin
                if (out_busy !== 1'b1) busy_lost = 1'b1;
                h++;
                @(negedge clk);
            end
            total++;
            if (h !== thi) begin
                bad++;
                $display("FAIL %s_high bit=%0d got=%0d want=%0d", name, i, h, thi);
            end
            if (i > 0) begin
                l = 0;
                while (out_sdata === 1'b0 && l < 300) begin
                    if (out_busy !== 1'b1) busy_lost = 1'b1;
                    l++;
                    @(negedge clk);
                end
                total++;
                if (l !== 120 - thi) begin
                    bad++;
                    $display("FAIL %s_low bit=%0d got=%0d want=%0d", name, i, l, 120 - thi);
                end
            end else begin
                t = 0;
                errs = 0;
                while (out_busy === 1'b1 && t < 20000) begin
                    if (out_sdata !== 1'b0) errs++;
                    if (chk_ready && in_ready !== 1'b0) errs++;
                    t++;
                    @(negedge clk);
                end
                total++;
                if (t !== tail) begin
                    bad++;
                    $display("FAIL %s_tail got=%0d want=%0d", name, t, tail);
                end
                total++;
                if (errs !== 0) begin
                    bad++;
                    $display("FAIL %s_tail_line got=%0d bad cycles want=0", name, errs);
                end
            end
        end
        total++;
        if (busy_lost) begin
            bad++;
            $display("FAIL %s_busy got=dropped want=held", name);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if (out_busy !== 1'b0 || out_sdata !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle got=busy%b sdata%b ready%b want=busy0 sdata0 ready1",
                     name, out_busy, out_sdata, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_word = '0;
        in_latch = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_sdata !== 1'b0 || out_busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=sdata%b busy%b ready%b want=000",
                     out_sdata, out_busy, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single;
        send(32'hFF00_8001, 1'b0, wt);
        measure("single", {32'h0, 32'hFF00_8001}, 32, 43 + AL, 1'b0);
        check_idle("single");
    endtask

    task automatic test_back_to_back;
        send(32'hA5C3_0F96, 1'b0, wt);
        fork
            send(32'h1234_8765, 1'b1, wt2);
            measure("b2b", {32'hA5C3_0F96, 32'h1234_8765}, 64, 43 + 7680, 1'b1);
        join
        total++;
        if (wt2 !== 3839) begin
            bad++;
            $display("FAIL b2b_holdoff got=%0d want=3839", wt2);
        end
        check_idle("b2b");
    endtask

    task automatic test_reset_midbit;
        send(32'hFFFF_FFFF, 1'b0, wt);
        repeat (5 * 120 + 9) @(negedge clk);
        total++;
        if (out_sdata !== 1'b1) begin
            bad++;
            $display("FAIL midbit_pre got=%b want=1", out_sdata);
        end
        rst = 1'b1;
        #1;
        total++;
        if (out_sdata !== 1'b0 || out_busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midbit_reset got=sdata%b busy%b ready%b want=000",
                     out_sdata, out_busy, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'h8000_0001, 1'b0, wt);
        measure("after_rst", {32'h0, 32'h8000_0001}, 32, 43 + AL, 1'b0);
        check_idle("after_rst");
    endtask

    task automatic test_underrun_zero;
        send(32'h0000_0000, 1'b0, wt);
        measure("zero", 64'h0, 32, 82 + AL, 1'b0);
        check_idle("zero");
    endtask

    task automatic test_all_ones;
        send(32'hFFFF_FFFF, 1'b0, wt);
        measure("ones", {32'h0, 32'hFFFF_FFFF}, 32, 43 + AL, 1'b0);
        check_idle("ones");
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_reset_midbit;
        test_underrun_zero;
        test_all_ones;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
